// File: rtl/tl_tick_ctrl_if.sv
// Key inputs and timer-control outputs of the tick controller.
// The Fast input exists only when TL_TICK_FAST_EN is defined.
interface tl_tick_ctrl_if;
    logic Key_start;
    logic Key_step;
`ifdef TL_TICK_FAST_EN
    logic Fast;
`endif
    logic en;
    logic tick_1s;
    logic Run_led;

    modport master (
        output Key_start,
        output Key_step,
`ifdef TL_TICK_FAST_EN
        output Fast,
`endif
        input  en,
        input  tick_1s,
        input  Run_led
    );

    modport slave (
        input  Key_start,
        input  Key_step,
`ifdef TL_TICK_FAST_EN
        input  Fast,
`endif
        output en,
        output tick_1s,
        output Run_led
    );
endinterface

// File: rtl/tl_tick_ctrl.sv
// Run/pause controller and 1 s time base for the traffic-light timer.
// Optional TL_TICK_FAST_EN adds a Fast input that shortens the tick period.
module tl_tick_ctrl #(
    parameter int unsigned TICK_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20
`ifdef TL_TICK_FAST_EN
    ,
    parameter int unsigned FAST_FACTOR     = 10
`endif
) (
    input logic           Clk,
    input logic           Rst,
    tl_tick_ctrl_if.slave bus
);

    localparam int unsigned CntW = $clog2(TICK_DIV);
    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CntW-1:0] WrapFull = CntW'(TICK_DIV - 1);
    localparam logic [DbW-1:0]  DbLast   = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    // Index 0 is Start/Pause, index 1 is Step.
    logic [1:0]     key_raw;
    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     acc_q, acc_d;
    logic [DbW-1:0] db_cnt_q [2];
    logic [DbW-1:0] db_cnt_d [2];
    logic [1:0]     press;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] wrap_val;
    logic            en_q, en_d;
    logic            tick_q, tick_d;
    logic            led_q, led_d;
    logic            start_evt, step_evt, step_pulse, wrap_hit;

    assign key_raw = {bus.Key_step, bus.Key_start};

`ifdef TL_TICK_FAST_EN
    localparam logic [CntW-1:0] WrapFast = CntW'(TICK_DIV / FAST_FACTOR - 1);

    logic fast_s1_q, fast_s2_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            fast_s1_q <= 1'b0;
            fast_s2_q <= 1'b0;
        end else begin
            fast_s1_q <= bus.Fast;
            fast_s2_q <= fast_s1_q;
        end
    end

    assign wrap_val = fast_s2_q ? WrapFast : WrapFull;
`else
    assign wrap_val = WrapFull;
`endif

    // The press event fires on the same edge the accepted level rises.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            acc_d[k]    = acc_q[k];
            db_cnt_d[k] = '0;
            press[k]    = 1'b0;
            if (sync2_q[k] != acc_q[k]) begin
                if (db_cnt_q[k] == DbLast) begin
                    acc_d[k] = sync2_q[k];
                    press[k] = sync2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DbW'(1);
                end
            end
        end
    end

    assign start_evt = press[0];
    assign step_evt  = press[1];

    always_comb begin
        state_d    = state_q;
        step_pulse = 1'b0;
        unique case (state_q)
            StIdle:  if (start_evt) state_d = StRun;
            StRun:   if (start_evt) state_d = StPause;
            StPause: begin
                if (start_evt) begin
                    state_d = StRun;
                end else if (step_evt) begin
                    step_pulse = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The prescaler only advances on edges that begin and end in RUN, so the
    // entry edge and the pause edge leave the accumulated phase untouched.
    always_comb begin
        wrap_hit = (cnt_q >= wrap_val);
        cnt_d    = cnt_q;
        tick_d   = step_pulse;
        if (state_d == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StRun && state_d == StRun) begin
            tick_d = wrap_hit;
            cnt_d  = wrap_hit ? '0 : cnt_q + CntW'(1);
        end
        en_d  = (state_d == StRun) | step_pulse;
        led_d = (state_d == StRun);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            acc_q    <= '0;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= '0;
            end
            state_q  <= StIdle;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            tick_q   <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            sync1_q  <= key_raw;
            sync2_q  <= sync1_q;
            acc_q    <= acc_d;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
            end
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            tick_q   <= tick_d;
            led_q    <= led_d;
        end
    end

    assign bus.en      = en_q;
    assign bus.tick_1s = tick_q;
    assign bus.Run_led = led_q;

endmodule

// File: tb/tb_tl_tick_ctrl.sv
// Scoreboard bench for tl_tick_ctrl with TICK_DIV=10, DEBOUNCE_CYCLES=4.
// Edge k is the k-th rising edge after the scenario's reset is released.
module tb_tl_tick_ctrl;
    localparam int unsigned TD = 10;
    localparam int unsigned DB = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    tl_tick_ctrl_if bus_if ();

    tl_tick_ctrl #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DB)
`ifdef TL_TICK_FAST_EN
        ,
        .FAST_FACTOR     (5)
`endif
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_if.slave)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];  // {en, tick_1s, Run_led}

    function automatic bit rng(int k, int a, int b);
        return (k >= a) && (k <= b);
    endfunction

    task automatic do_reset();
        Rst = 1'b1;
        bus_if.Key_start = 1'b0;
        bus_if.Key_step  = 1'b0;
`ifdef TL_TICK_FAST_EN
        bus_if.Fast = 1'b0;
`endif
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] obs;
        Rst = 1'b1;
        bus_if.Key_start = 1'b0;
        bus_if.Key_step  = 1'b0;
`ifdef TL_TICK_FAST_EN
        bus_if.Fast = 1'b0;
`endif
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        for (int k = 1; k <= 2; k++) begin
            @(posedge Clk);
            #1;
            obs = {bus_if.en, bus_if.tick_1s, bus_if.Run_led};
            checks++;
            if (obs !== exp_q.pop_front()) begin
                errors++;
                $display("FAIL reset edge %0d en/tick/led got %b want 000", k, obs);
            end
        end
        Rst = 1'b0;
    endtask

    // Held key: RUN at edge 6, ticks at 16, 26, 36; holding never pauses.
    task automatic test_run_ticks();
        logic [2:0] obs, exp;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            exp_q.push_back({k >= 6, (k >= 16) && ((k - 16) % 10 == 0), k >= 6});
        end
        for (int k = 1; k <= 40; k++) begin
            bus_if.Key_start = 1'b1;
            @(posedge Clk);
            #1;
            obs = {bus_if.en, bus_if.tick_1s, bus_if.Run_led};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL run_ticks edge %0d en/tick/led got %b want %b", k, obs, exp);
            end
        end
    endtask

    // 3-cycle glitch is dropped; 4-cycle pulse starting at edge 13 runs at 18.
    task automatic test_glitch();
        logic [2:0] obs, exp;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            exp_q.push_back({k >= 18, k == 28, k >= 18});
        end
        for (int k = 1; k <= 30; k++) begin
            bus_if.Key_start = rng(k, 1, 3) || rng(k, 13, 16);
            @(posedge Clk);
            #1;
            obs = {bus_if.en, bus_if.tick_1s, bus_if.Run_led};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL glitch edge %0d en/tick/led got %b want %b", k, obs, exp);
            end
        end
    endtask

    // Pause lands at edge 26 with cnt at 9; resume at 46 ticks at 47.
    task automatic test_pause_wrap();
        logic [2:0] obs, exp;
        logic       run;
        do_reset();
        for (int k = 1; k <= 70; k++) begin
            run = rng(k, 6, 25) || (k >= 46);
            exp_q.push_back({run, (k == 16) || (k == 47) || (k == 57) || (k == 67), run});
        end
        for (int k = 1; k <= 70; k++) begin
            bus_if.Key_start = rng(k, 1, 10) || rng(k, 21, 30) || rng(k, 41, 50);
            @(posedge Clk);
            #1;
            obs = {bus_if.en, bus_if.tick_1s, bus_if.Run_led};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL pause_wrap edge %0d en/tick/led got %b want %b", k, obs, exp);
            end
        end
    endtask

    // Pause at 24 (cnt 7), step at 36, resume at 46, ticks 49/59; step in RUN at 56.
    task automatic test_step();
        logic [2:0] obs, exp;
        logic       run;
        do_reset();
        for (int k = 1; k <= 62; k++) begin
            run = rng(k, 6, 23) || (k >= 46);
            exp_q.push_back({run || (k == 36), (k == 16) || (k == 36) || (k == 49) || (k == 59),
                             run});
        end
        for (int k = 1; k <= 62; k++) begin
            bus_if.Key_start = rng(k, 1, 8) || rng(k, 19, 26) || rng(k, 41, 48);
            bus_if.Key_step  = rng(k, 31, 38) || rng(k, 51, 58);
            @(posedge Clk);
            #1;
            obs = {bus_if.en, bus_if.tick_1s, bus_if.Run_led};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL step edge %0d en/tick/led got %b want %b", k, obs, exp);
            end
        end
        // Step in IDLE is ignored.
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            exp_q.push_back(3'b000);
        end
        for (int k = 1; k <= 12; k++) begin
            bus_if.Key_step = rng(k, 1, 8);
            @(posedge Clk);
            #1;
            obs = {bus_if.en, bus_if.tick_1s, bus_if.Run_led};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL step_idle edge %0d en/tick/led got %b want %b", k, obs, exp);
            end
        end
    endtask

    // Start and step together in PAUSE resume without a step pulse; Rst at
    // edge 45 (cnt 5) returns to IDLE with cnt 0, proven by the next tick spacing.
    task automatic test_both_and_reset();
        logic [2:0] obs, exp;
        logic       run;
        do_reset();
        for (int k = 1; k <= 72; k++) begin
            run = rng(k, 6, 23) || rng(k, 36, 44) || (k >= 51);
            exp_q.push_back({run, (k == 16) || (k == 39) || (k == 61) || (k == 71), run});
        end
        for (int k = 1; k <= 72; k++) begin
            bus_if.Key_start = rng(k, 1, 8) || rng(k, 19, 26) || rng(k, 31, 38) ||
                               rng(k, 46, 53);
            bus_if.Key_step  = rng(k, 31, 38);
            Rst = (k == 45);
            @(posedge Clk);
            #1;
            obs = {bus_if.en, bus_if.tick_1s, bus_if.Run_led};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL both_reset edge %0d en/tick/led got %b want %b", k, obs, exp);
            end
        end
        Rst = 1'b0;
    endtask

`ifdef TL_TICK_FAST_EN
    // Fast from edge 27 gives ticks every 2 cycles from 29; off from 41 resumes 10.
    task automatic test_fast();
        logic [2:0] obs, exp;
        logic       tk;
        do_reset();
        for (int k = 1; k <= 62; k++) begin
            tk = (k == 16) || (k == 26) || (rng(k, 29, 41) && (k % 2 == 1)) ||
                 (k == 51) || (k == 61);
            exp_q.push_back({k >= 6, tk, k >= 6});
        end
        for (int k = 1; k <= 62; k++) begin
            bus_if.Key_start = rng(k, 1, 8);
            bus_if.Fast      = rng(k, 27, 40);
            @(posedge Clk);
            #1;
            obs = {bus_if.en, bus_if.tick_1s, bus_if.Run_led};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL fast edge %0d en/tick/led got %b want %b", k, obs, exp);
            end
        end
    endtask
`endif

    initial begin
        bus_if.Key_start = 1'b0;
        bus_if.Key_step  = 1'b0;
`ifdef TL_TICK_FAST_EN
        bus_if.Fast = 1'b0;
`endif
        test_reset();
        test_run_ticks();
        test_glitch();
        test_pause_wrap();
        test_step();
        test_both_and_reset();
`ifdef TL_TICK_FAST_EN
        test_fast();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
